lgn_frame_sequencer: RTL and testbench
======================================

# lgn_frame_sequencer

Frame-level controller in front of the `lgn` inference core. It accepts one 28×28 binary image as 98 bytes over a valid/ready stream and drives the core's byte-shift load port. It then holds the image stable for a fixed settle window while the combinational net and arg-max resolve, and captures the winning class index and score into a registered result presented over a second valid/ready handshake. It sits between the chip I/O adapter and `lgn`, and owns all framing, error and throughput bookkeeping.

## Interface
Parameters:
- `INPUT_BITS`, 784: image bits; must be a multiple of 8; `BYTES_PER_FRAME = INPUT_BITS/8` (98).
- `SETTLE_CYCLES`, 4: cycles between last byte shift and result capture; legal range 1..15.
- `SCORE_W`, 8: width of captured score, which is the top bits of the core's category sum.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: sequencer accepts a byte.
- `in_data` in 8: image byte, MSB-first in shift order.
- `in_last` in 1: marks final byte of a frame.
- `lgn_write_enable` out 1: shift strobe to core.
- `lgn_data` out 8: byte to core.
- `lgn_index` in 4: core best-category index (combinational).
- `lgn_value` in `SCORE_W`: core best-category score (combinational).
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes result.
- `res_index` out 4: captured class 0..9.
- `res_value` out `SCORE_W`: captured score.
- `busy` out 1: state ≠ IDLE.
- `frame_err` out 1: sticky framing error.
- `frame_cnt` out 16: completed results, wraps 0xFFFF→0.
- `err_clr` in 1: clears `frame_err`.

## Operation
- States: IDLE, LOAD, SETTLE, RESULT.
- IDLE: `in_ready`=1. An accepted byte (`in_valid&&in_ready`) moves to LOAD and sets byte counter to 1.
- LOAD: `in_ready`=1. Each accepted byte increments the counter (0..97).
- Byte path: `lgn_write_enable = in_valid && in_ready`, and `lgn_data = in_data`, both combinational pass-through. The core shifts on the same edge the byte is accepted.
- Framing, checked on each accepted byte:
  - Counter reaching 98 with `in_last`=1: go to SETTLE, load settle counter with `SETTLE_CYCLES`.
  - `in_last`=1 before byte 98: set `frame_err` and return to IDLE. The partial image is discarded and no result is produced.
  - Byte 98 with `in_last`=0: set `frame_err` and return to IDLE.
- SETTLE: `in_ready`=0. Decrement every cycle. On the cycle the counter is 1, capture `lgn_index`/`lgn_value` into `res_*`, set `res_valid`, increment `frame_cnt`, and go to RESULT.
- RESULT: `in_ready`=0. `res_valid` is held and `res_*` are stable until `res_valid&&res_ready`, then go to IDLE. `res_*` keep their last values after the handshake.
- `err_clr` clears `frame_err` the next edge. A simultaneous new error wins, so the flag stays set.
- `frame_cnt` uses 16-bit modulo arithmetic.

## Timing
- Reset values:
  - State IDLE, counters 0.
  - `in_ready`=1, `lgn_write_enable`=0 (no valid).
  - `res_valid`=0, `res_index`=0, `res_value`=0.
  - `busy`=0, `frame_err`=0, `frame_cnt`=0.
- Throughput: 1 byte/cycle in IDLE/LOAD.
- Latency: last byte accepted at edge N, then `res_valid`=1 after edge N+`SETTLE_CYCLES`.
- Minimum frame period: 98 + `SETTLE_CYCLES` + 1 cycles, with `res_ready` tied high.
- `res_ready` may be asserted before `res_valid`; the handshake completes on the first edge both are high.
- `rst_n` low mid-LOAD/SETTLE/RESULT: immediate return to reset values. Any pending result is lost and `frame_cnt` is not incremented. The core's image register is not cleared, so the next frame fully overwrites it.
- `in_valid` with `in_ready`=0: ignored, no shift.

## Structure
- Shared `lgn_pkg`:
  - State enum `lgn_seq_state_t`.
  - `LGN_INPUT_BITS`=784, `LGN_BYTES_PER_FRAME`=98, `LGN_CATEGORIES`=10.
  - Result struct `{index[3:0], value[SCORE_W-1:0]}`.
- One natural sub-module `lgn_frame_counter`: 7-bit byte counter with `terminal` (==98) flag, reused by the stimulus driver in the testbench.

## Test plan
- Reset, then 98 bytes back-to-back with `in_last` on byte 98; core stub returns index 7, value 0x5A; `res_ready`=1 → 98 `lgn_write_enable` pulses, `res_valid` exactly `SETTLE_CYCLES` cycles after last byte, `res_index`=7, `res_value`=0x5A, `frame_cnt`=1.
- Same frame with `res_ready`=0 for 20 cycles, stub output changed to index 3 after capture → `res_*` stay 7/0x5A, `in_ready`=0 throughout, next frame accepted only after handshake.
- `in_last` on byte 50 → `frame_err`=1, state IDLE, no `res_valid`, `frame_cnt` unchanged; then `err_clr` → `frame_err`=0.
- Byte 98 with `in_last`=0 → `frame_err`=1, IDLE; following correct frame yields a result.
- `rst_n` pulsed low at byte 40 and again during SETTLE → all outputs at reset values, no result, `frame_cnt` unchanged.
- 65,537 frames via forced counter preload at 0xFFFF → `frame_cnt` wraps to 0x0000 then 0x0001.

Source files
------------

// File: rtl/lgn_pkg.sv
// Shared types and constants for the lgn core and its frame sequencer.
package lgn_pkg;
  localparam int LGN_INPUT_BITS      = 784;
  localparam int LGN_BYTES_PER_FRAME = LGN_INPUT_BITS / 8;
  localparam int LGN_CATEGORIES      = 10;
  localparam int LGN_SCORE_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RESULT
  } lgn_seq_state_t;

  typedef struct packed {
    logic [3:0]             index;
    logic [LGN_SCORE_W-1:0] value;
  } lgn_result_t;
endpackage

// File: rtl/lgn_frame_sequencer_if.sv
// Byte stream in, core shift/result port, result stream out.
interface lgn_frame_sequencer_if #(parameter int SCORE_W = 8);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               lgn_write_enable;
  logic [7:0]         lgn_data;
  logic [3:0]         lgn_index;
  logic [SCORE_W-1:0] lgn_value;
  logic               res_valid;
  logic               res_ready;
  logic [3:0]         res_index;
  logic [SCORE_W-1:0] res_value;

  // master = byte producer, core and result consumer seen together
  modport master (
    output in_valid, in_data, in_last, lgn_index, lgn_value, res_ready,
    input  in_ready, lgn_write_enable, lgn_data, res_valid, res_index, res_value
  );
  modport slave (
    input  in_valid, in_data, in_last, lgn_index, lgn_value, res_ready,
    output in_ready, lgn_write_enable, lgn_data, res_valid, res_index, res_value
  );
endinterface

// File: rtl/lgn_frame_counter.sv
// 7-bit byte counter; terminal flags that the next increment lands on TERM.
module lgn_frame_counter #(
  parameter int TERM = 98
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [6:0] count,
  output logic       terminal
);
  logic [6:0] count_q, count_d;

  always_comb count_d = clr ? 7'd0 : count_q + {6'd0, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 7'd0;
    else        count_q <= count_d;
  end

  assign count    = count_q;
  assign terminal = (count_q == 7'(TERM - 1));
endmodule

// File: rtl/lgn_frame_sequencer.sv
// Frames 98-byte images into the lgn core, waits out the settle window and
// registers the arg-max result behind a valid/ready handshake.
module lgn_frame_sequencer
  import lgn_pkg::*;
#(
  parameter int INPUT_BITS    = 784,
  parameter int SETTLE_CYCLES = 4,
  parameter int SCORE_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lgn_frame_sequencer_if.slave  bus,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);
  localparam int BYTES_PER_FRAME = INPUT_BITS / 8;

  typedef struct packed {
    logic [3:0]         index;
    logic [SCORE_W-1:0] value;
  } res_t;

  lgn_seq_state_t state_q, state_d;
  logic [3:0]     settle_q, settle_d;
  res_t           res_q, res_d;
  logic           frame_err_q, frame_err_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           in_ready, accept, byte_clr, byte_inc, terminal;
  logic [6:0]     byte_cnt;
  logic           unused_byte_cnt;

  lgn_frame_counter #(.TERM(BYTES_PER_FRAME)) u_byte_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (byte_clr),
    .inc      (byte_inc),
    .count    (byte_cnt),
    .terminal (terminal)
  );
  assign unused_byte_cnt = ^byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      settle_q    <= 4'd0;
      res_q       <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      res_q       <= res_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    res_d       = res_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    byte_clr    = 1'b0;
    byte_inc    = 1'b0;
    if (err_clr) frame_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          // Byte counter is cleared on every frame end so IDLE always starts from 0.
          if (bus.in_last || terminal) begin
            byte_clr = 1'b1;
            if (bus.in_last && terminal) begin
              state_d  = ST_SETTLE;
              settle_d = 4'(SETTLE_CYCLES);
            end else begin
              state_d     = ST_IDLE;
              frame_err_d = 1'b1;
            end
          end else begin
            byte_inc = 1'b1;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) begin
          state_d     = ST_RESULT;
          res_d       = '{index: bus.lgn_index, value: bus.lgn_value};
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      ST_RESULT: if (bus.res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready             = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    accept               = bus.in_valid && in_ready;
    bus.in_ready         = in_ready;
    bus.lgn_write_enable = accept;
    bus.lgn_data         = bus.in_data;
    bus.res_valid        = (state_q == ST_RESULT);
    bus.res_index        = res_q.index;
    bus.res_value        = res_q.value;
    busy                 = (state_q != ST_IDLE);
    frame_err            = frame_err_q;
    frame_cnt            = frame_cnt_q;
  end
endmodule

// File: tb/tb_lgn_frame_sequencer.sv
// Directed bench for lgn_frame_sequencer with a stubbed lgn core.
module tb_lgn_frame_sequencer;
  import lgn_pkg::*;
  localparam int SETTLE = 4;

  logic        clk, rst_n, err_clr;
  logic        busy, frame_err;
  logic [15:0] frame_cnt;
  logic        sh_clr, sh_term;
  logic [6:0]  sh_cnt;
  int          tests = 0;
  int          fails = 0;
  int          cyc;

  lgn_frame_sequencer_if #(.SCORE_W(8)) bus ();

  lgn_frame_sequencer #(.INPUT_BITS(784), .SETTLE_CYCLES(SETTLE), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr),
    .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // Counts shift strobes seen by the core.
  lgn_frame_counter #(.TERM(LGN_BYTES_PER_FRAME)) u_shadow (
    .clk(clk), .rst_n(rst_n), .clr(sh_clr), .inc(bus.lgn_write_enable),
    .count(sh_cnt), .terminal(sh_term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int n, input int last_at);
    sh_clr = 1'b1;
    tick();
    sh_clr = 1'b0;
    for (int i = 1; i <= n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      bus.in_last  = (i == last_at);
      #1;
      if (i == 1) begin
        chk("lgn_we_pass", {31'd0, bus.lgn_write_enable}, 32'd1);
        chk("lgn_data_pass", {24'd0, bus.lgn_data}, 32'd1);
      end
      if (i == 98) chk("shadow_terminal", {31'd0, sh_term}, 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_res(output int c);
    c = 0;
    while (!bus.res_valid && c < 40) begin
      tick();
      c++;
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.res_ready = 0;
    bus.lgn_index = 0; bus.lgn_value = 0;
    err_clr = 0; sh_clr = 0; rst_n = 0;
    #12;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_lgn_we", {31'd0, bus.lgn_write_enable}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_index", {28'd0, bus.res_index}, 32'd0);
    chk("rst_res_value", {24'd0, bus.res_value}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Good frame, consumer always ready
    bus.lgn_index = 4'd7; bus.lgn_value = 8'h5A; bus.res_ready = 1'b1;
    send_frame(98, 98);
    chk("f1_shifts", {25'd0, sh_cnt}, 32'd98);
    chk("f1_busy_settle", {31'd0, busy}, 32'd1);
    wait_res(cyc);
    chk("f1_latency", cyc, SETTLE);
    chk("f1_index", {28'd0, bus.res_index}, 32'd7);
    chk("f1_value", {24'd0, bus.res_value}, 32'h5A);
    chk("f1_cnt", {16'd0, frame_cnt}, 32'd1);
    tick();
    chk("f1_released", {31'd0, bus.res_valid}, 32'd0);
    chk("f1_idle", {31'd0, busy}, 32'd0);

    // Back-pressured result; stub changes after capture
    bus.res_ready = 1'b0;
    send_frame(98, 98);
    wait_res(cyc);
    chk("f2_latency", cyc, SETTLE);
    bus.lgn_index = 4'd3; bus.lgn_value = 8'h11; bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("f2_hold_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("f2_hold_index", {28'd0, bus.res_index}, 32'd7);
      chk("f2_hold_value", {24'd0, bus.res_value}, 32'h5A);
      chk("f2_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("f2_no_shift", {31'd0, bus.lgn_write_enable}, 32'd0);
    end
    bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    tick();
    chk("f2_released", {31'd0, bus.res_valid}, 32'd0);
    chk("f2_cnt", {16'd0, frame_cnt}, 32'd2);
    chk("f2_index_kept", {28'd0, bus.res_index}, 32'd7);
    chk("f2_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

    // Early in_last on byte 50
    send_frame(50, 50);
    chk("early_err", {31'd0, frame_err}, 32'd1);
    chk("early_idle", {31'd0, busy}, 32'd0);
    chk("early_shifts", {25'd0, sh_cnt}, 32'd50);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("early_no_res", {31'd0, bus.res_valid}, 32'd0);
    end
    chk("early_cnt", {16'd0, frame_cnt}, 32'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", {31'd0, frame_err}, 32'd0);

    // Byte 98 without in_last, with err_clr held: the new error wins
    err_clr = 1'b1;
    send_frame(98, 0);
    chk("late_err_wins", {31'd0, frame_err}, 32'd1);
    chk("late_idle", {31'd0, busy}, 32'd0);
    err_clr = 1'b0;
    tick();
    chk("late_err_sticky", {31'd0, frame_err}, 32'd1);
    bus.lgn_index = 4'd5; bus.lgn_value = 8'h33;
    send_frame(98, 98);
    wait_res(cyc);
    chk("f3_latency", cyc, SETTLE);
    chk("f3_index", {28'd0, bus.res_index}, 32'd5);
    chk("f3_value", {24'd0, bus.res_value}, 32'h33);
    chk("f3_cnt", {16'd0, frame_cnt}, 32'd3);
    tick();

    // Reset in LOAD at byte 40
    send_frame(40, 0);
    rst_n = 1'b0;
    #1;
    chk("rl_busy", {31'd0, busy}, 32'd0);
    chk("rl_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rl_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rl_res_index", {28'd0, bus.res_index}, 32'd0);
    chk("rl_res_value", {24'd0, bus.res_value}, 32'd0);
    chk("rl_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rl_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset in SETTLE
    bus.lgn_index = 4'd9; bus.lgn_value = 8'h77;
    send_frame(98, 98);
    tick();
    chk("rs_in_settle", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_res_valid", {31'd0, bus.res_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rs_no_res", {31'd0, bus.res_valid}, 32'd0);
    end
    chk("rs_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rs_res_index", {28'd0, bus.res_index}, 32'd0);
    send_frame(98, 98);
    wait_res(cyc);
    chk("f4_latency", cyc, SETTLE);
    chk("f4_index", {28'd0, bus.res_index}, 32'd9);
    chk("f4_value", {24'd0, bus.res_value}, 32'h77);
    chk("f4_cnt", {16'd0, frame_cnt}, 32'd1);
    tick();

    // frame_cnt wrap from a preloaded 0xFFFF
    force dut.frame_cnt_q = 16'hFFFF;
    #2;
    release dut.frame_cnt_q;
    tick();
    chk("wrap_preload", {16'd0, frame_cnt}, 32'hFFFF);
    bus.lgn_index = 4'd1; bus.lgn_value = 8'h01;
    send_frame(98, 98);
    wait_res(cyc);
    chk("wrap_zero", {16'd0, frame_cnt}, 32'h0000);
    tick();
    bus.lgn_index = 4'd2; bus.lgn_value = 8'h02;
    send_frame(98, 98);
    wait_res(cyc);
    chk("wrap_one", {16'd0, frame_cnt}, 32'h0001);
    chk("wrap_index", {28'd0, bus.res_index}, 32'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
